// File: rtl/data_ram_arbiter_pkg.sv
// data_ram_arbiter_pkg: shared bus widths, RAM depth and sequencer state encodings
package data_ram_arbiter_pkg;
  localparam int ADDRESS_BUS_WIDTH = 10;
  localparam int DATA_BUS_WIDTH = 64;
  localparam logic [ADDRESS_BUS_WIDTH-1:0] NUM_DATA_ADDRESSES = ADDRESS_BUS_WIDTH'(512);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
endpackage

// File: rtl/data_ram_arbiter_rr.sv
// rr_arbiter2: two-way round-robin arbiter; last_grant names the port that won the last handshake
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last_grant
);
  always_comb begin
    grant[0] = req[0] & (~req[1] | last_grant);
    grant[1] = req[1] & (~req[0] | ~last_grant);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= 1'b1;
    else if (advance) last_grant <= grant[1];
endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: two-port round-robin sequencer in front of the single-port data RAM
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         p0_valid,
  input  logic                         p0_write,
  input  logic [ADDRESS_BUS_WIDTH-1:0] p0_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    p0_wdata,
  output logic                         p0_ready,
  output logic                         p0_rvalid,
  output logic [DATA_BUS_WIDTH-1:0]    p0_rdata,
  input  logic                         p1_valid,
  input  logic                         p1_write,
  input  logic [ADDRESS_BUS_WIDTH-1:0] p1_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    p1_wdata,
  output logic                         p1_ready,
  output logic                         p1_rvalid,
  output logic [DATA_BUS_WIDTH-1:0]    p1_rdata,
  output logic                         oob_err,
  output logic                         ram_cs,
  output logic                         ram_memRead,
  output logic                         ram_memWrite,
  output logic [ADDRESS_BUS_WIDTH-1:0] ram_address,
  output logic [DATA_BUS_WIDTH-1:0]    ram_writeData,
  input  logic [DATA_BUS_WIDTH-1:0]    ram_readData
);
  logic [1:0] state, grant;
  logic last_grant, idle, hs, sel_write, sel_oob, cmd_write, cmd_oob;
  logic [ADDRESS_BUS_WIDTH-1:0] sel_addr;
  logic [DATA_BUS_WIDTH-1:0] sel_wdata, cap_data;
  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       ({p1_valid, p0_valid}),
    .advance   (hs),
    .grant     (grant),
    .last_grant(last_grant)
  );
  always_comb begin
    idle = state == ST_IDLE;
    hs = idle & |grant;
    p0_ready = idle & grant[0];
    p1_ready = idle & grant[1];
    sel_write = grant[1] ? p1_write : p0_write;
    sel_addr = grant[1] ? p1_addr : p0_addr;
    sel_wdata = grant[1] ? p1_wdata : p0_wdata;
    sel_oob = sel_addr >= NUM_DATA_ADDRESSES;
    cap_data = cmd_oob ? '0 : ram_readData;
  end
  // last_grant only moves on a handshake, so it names the owner of the op in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      cmd_write <= 1'b0;
      cmd_oob <= 1'b0;
      oob_err <= 1'b0;
      ram_cs <= 1'b0;
      ram_memRead <= 1'b0;
      ram_memWrite <= 1'b0;
      ram_address <= '0;
      ram_writeData <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      oob_err <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      case (state)
        ST_IDLE: if (hs) begin
          state <= ST_ISSUE;
          cmd_write <= sel_write;
          cmd_oob <= sel_oob;
          ram_cs <= ~sel_oob;
          ram_memRead <= ~sel_oob & ~sel_write;
          ram_memWrite <= ~sel_oob & sel_write;
          ram_address <= sel_addr;
          ram_writeData <= sel_wdata;
        end
        ST_ISSUE: begin
          state <= cmd_write ? ST_IDLE : ST_CAPTURE;
          ram_cs <= ~cmd_oob & ~cmd_write;
          ram_memRead <= 1'b0;
          ram_memWrite <= 1'b0;
          oob_err <= cmd_oob;
        end
        ST_CAPTURE: begin
          state <= ST_IDLE;
          ram_cs <= 1'b0;
          if (last_grant) begin
            p1_rvalid <= 1'b1;
            p1_rdata <= cap_data;
          end else begin
            p0_rvalid <= 1'b1;
            p0_rdata <= cap_data;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: scoreboard bench with a behavioural RAM and array-based reference model
module tb_data_ram_arbiter;
  import data_ram_arbiter_pkg::*;
  typedef struct {int due; logic [DATA_BUS_WIDTH-1:0] d;} exp_t;
  logic clk = 1'b0, reset = 1'b1, ram_init = 1'b1;
  logic [1:0] vld = '0, wr = '0, hs = '0, rdy, rv;
  logic [ADDRESS_BUS_WIDTH-1:0] ad [2];
  logic [DATA_BUS_WIDTH-1:0] wd [2], rd [2];
  logic oob_err, ram_cs, ram_memRead, ram_memWrite;
  logic [ADDRESS_BUS_WIDTH-1:0] ram_address;
  logic [DATA_BUS_WIDTH-1:0] ram_writeData, ram_readData;
  logic [DATA_BUS_WIDTH-1:0] mem [512];
  logic [DATA_BUS_WIDTH-1:0] ref_mem [512];
  exp_t q0[$], q1[$];
  exp_t mon_e;
  int cyc = 0, n_cmp = 0, n_bad = 0, exp_oob = 0, seen_oob = 0, got = -1;
  int hs_cyc [2];
  bit skip = 1'b0;
  data_ram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .p0_valid     (vld[0]),
    .p0_write     (wr[0]),
    .p0_addr      (ad[0]),
    .p0_wdata     (wd[0]),
    .p0_ready     (rdy[0]),
    .p0_rvalid    (rv[0]),
    .p0_rdata     (rd[0]),
    .p1_valid     (vld[1]),
    .p1_write     (wr[1]),
    .p1_addr      (ad[1]),
    .p1_wdata     (wd[1]),
    .p1_ready     (rdy[1]),
    .p1_rvalid    (rv[1]),
    .p1_rdata     (rd[1]),
    .oob_err      (oob_err),
    .ram_cs       (ram_cs),
    .ram_memRead  (ram_memRead),
    .ram_memWrite (ram_memWrite),
    .ram_address  (ram_address),
    .ram_writeData(ram_writeData),
    .ram_readData (ram_readData)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // single-port RAM with one-cycle registered read; preloaded with mem[i] = i
  always @(posedge clk)
    if (ram_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= DATA_BUS_WIDTH'(i);
      ram_readData <= '0;
    end else if (ram_cs) begin
      if (ram_memWrite) mem[ram_address[8:0]] <= ram_writeData;
      if (ram_memRead) ram_readData <= mem[ram_address[8:0]];
    end
  always @(negedge clk)
    if (!reset) begin
      if (oob_err) seen_oob++;
      if (ram_cs) begin
        n_cmp++;
        if (ram_address >= 10'd512) begin
          n_bad++;
          $display("FAIL ram_cs_oob: cs high with address %0d, required < 512", ram_address);
        end
      end
      for (int p = 0; p < 2; p++)
        if (rv[p]) begin
          n_cmp++;
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            n_bad++;
            $display("FAIL p%0d_rvalid: unexpected pulse at cycle %0d rdata=%h, required no pulse", p, cyc, rd[p]);
          end else begin
            if (p == 0) mon_e = q0.pop_front();
            else mon_e = q1.pop_front();
            if (rd[p] !== mon_e.d || cyc != mon_e.due) begin
              n_bad++;
              $display("FAIL p%0d_rdata: got %h at cycle %0d, required %h at cycle %0d", p, rd[p], cyc, mon_e.d, mon_e.due);
            end
          end
        end
    end
  task automatic edge_start();
    @(negedge clk);
    for (int p = 0; p < 2; p++)
      if (hs[p]) begin
        vld[p] = 1'b0;
        hs[p] = 1'b0;
      end
  endtask
  task automatic set(int p, logic w, logic [ADDRESS_BUS_WIDTH-1:0] a, logic [DATA_BUS_WIDTH-1:0] d);
    vld[p] = 1'b1;
    wr[p] = w;
    ad[p] = a;
    wd[p] = d;
  endtask
  // a ready seen here is the handshake at the coming edge; the model applies it in order
  task automatic settle();
    exp_t e;
    #1;
    got = -1;
    n_cmp++;
    if (&rdy) begin
      n_bad++;
      $display("FAIL one_ready: ready=%b, required at most one bit", rdy);
    end
    for (int p = 0; p < 2; p++)
      if (vld[p] && rdy[p] && !hs[p]) begin
        hs[p] = 1'b1;
        hs_cyc[p] = cyc;
        got = p;
        if (ad[p] >= 10'd512) exp_oob++;
        if (wr[p]) begin
          if (ad[p] < 10'd512 && !skip) ref_mem[ad[p][8:0]] = wd[p];
        end else begin
          e.due = cyc + 3;
          e.d = (ad[p] < 10'd512) ? ref_mem[ad[p][8:0]] : '0;
          if (p == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
  endtask
  task automatic wait_hs(int p);
    int n = 0;
    while (!hs[p] && n < 20) begin
      edge_start();
      settle();
      n++;
    end
    n_cmp++;
    if (!hs[p]) begin
      n_bad++;
      $display("FAIL p%0d_handshake: ready=%b after 20 cycles, required 1", p, rdy[p]);
      vld[p] = 1'b0;
    end
  endtask
  task automatic do_req(int p, logic w, logic [ADDRESS_BUS_WIDTH-1:0] a, logic [DATA_BUS_WIDTH-1:0] d);
    edge_start();
    set(p, w, a, d);
    settle();
    wait_hs(p);
  endtask
  task automatic check(string name, logic [255:0] act, logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int c, prev, bad_rows;
    logic [DATA_BUS_WIDTH-1:0] x;
    for (int i = 0; i < 512; i++) ref_mem[i] = DATA_BUS_WIDTH'(i);
    for (int p = 0; p < 2; p++) begin
      ad[p] = '0;
      wd[p] = '0;
    end
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    check("reset_ctrl", 256'({rdy, rv, oob_err, ram_cs, ram_memRead, ram_memWrite, ram_address}), '0);
    check("reset_data", 256'({ram_writeData, rd[0], rd[1]}), '0);
    reset = 1'b0;
    do_req(0, 1'b0, 10'd49, '0);
    edge_start();
    check("issue_ctrl", 256'({ram_cs, ram_memRead, ram_memWrite, ram_address}), 256'({3'b110, 10'd49}));
    do_req(1, 1'b1, 10'd7, 64'hDEAD);
    do_req(0, 1'b0, 10'd7, '0);
    check("mem7_write", 256'(mem[7]), 256'(64'hDEAD));
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      edge_start();
      for (int p = 0; p < 2; p++) if (!vld[p]) set(p, 1'b0, 10'(p + 1), '0);
      settle();
      if (got >= 0) begin
        if (prev >= 0) check("alternate_grant", 256'(got), 256'(1 - prev));
        prev = got;
      end
    end
    edge_start();
    vld = '0;
    do_req(0, 1'b0, 10'd600, '0);
    edge_start();
    check("oob_read_cs", 256'(ram_cs), '0);
    do_req(0, 1'b1, 10'd600, 64'h1234);
    skip = 1'b1;
    do_req(0, 1'b1, 10'd3, 64'hFF);
    skip = 1'b0;
    @(posedge clk);
    #2;
    vld = '0;
    hs = '0;
    reset = 1'b1;
    #1;
    check("midreset_ctrl", 256'({rdy, rv, oob_err, ram_cs, ram_memRead, ram_memWrite, ram_address}), '0);
    check("midreset_data", 256'({ram_writeData, rd[0], rd[1]}), '0);
    edge_start();
    edge_start();
    reset = 1'b0;
    check("mem3_kept", 256'(mem[3]), 256'(3));
    edge_start();
    set(0, 1'b0, 10'd5, '0);
    set(1, 1'b0, 10'd6, '0);
    settle();
    check("first_grant_after_reset", 256'(got), '0);
    wait_hs(1);
    do_req(0, 1'b0, 10'd10, '0);
    c = hs_cyc[0];
    x = {$urandom, $urandom};
    do_req(0, 1'b1, 10'd11, x);
    check("b2b_accept_cycle", 256'(hs_cyc[0]), 256'(c + 3));
    edge_start();
    edge_start();
    check("mem11_write", 256'(mem[11]), 256'(x));
    for (int i = 0; i < 600; i++) begin
      edge_start();
      for (int p = 0; p < 2; p++)
        if (!vld[p] && $urandom_range(2) == 0)
          set(p, 1'($urandom_range(1)),
              ($urandom_range(7) == 0) ? 10'(512 + $urandom_range(511)) : 10'($urandom_range(511)),
              {$urandom, $urandom});
      settle();
    end
    edge_start();
    vld = '0;
    repeat (8) edge_start();
    check("q0_drained", 256'(q0.size()), '0);
    check("q1_drained", 256'(q1.size()), '0);
    check("oob_pulses", 256'(seen_oob), 256'(exp_oob));
    bad_rows = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad_rows++;
    check("mem_image_bad_rows", 256'(bad_rows), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data_ram. Port 0 is the CPU load/store path; port 1 is the loader/debug path. It round-robins requests, drives the RAM's cs/memRead/memWrite/address/writeData as registered signals, and handles the RAM's one-cycle registered read latency. Read data returns to the owning port with a one-cycle rvalid pulse.

Parameters:
ADDRESS_BUS_WIDTH, 10, address width (from params.v)
DATA_BUS_WIDTH, 64, data width (from params.v)
NUM_DATA_ADDRESSES, 512, number of valid RAM rows (NUM_ADDRESSES/2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
p0_valid / p1_valid  in  1  request pending; held with cmd fields until ready
p0_write / p1_write  in  1  1=write, 0=read
p0_addr / p1_addr  in  ADDRESS_BUS_WIDTH  row address
p0_wdata / p1_wdata  in  DATA_BUS_WIDTH  write data
p0_ready / p1_ready  out  1  combinational accept; handshake = valid&ready at clk edge
p0_rvalid / p1_rvalid  out  1  one-cycle read-data-valid pulse
p0_rdata / p1_rdata  out  DATA_BUS_WIDTH  read data, registered, held until next read to that port
oob_err  out  1  one-cycle pulse: accepted address >= NUM_DATA_ADDRESSES
ram_cs, ram_memRead, ram_memWrite  out  1  registered RAM controls
ram_address  out  ADDRESS_BUS_WIDTH  registered
ram_writeData  out  DATA_BUS_WIDTH  registered
ram_readData  in  DATA_BUS_WIDTH  RAM read data

Behaviour:
- Reset (async): state IDLE; all outputs and ram_* = 0; p*_rdata = 0; last_grant = 1 (port 0 wins first tie). An op in flight is dropped. If reset asserts during ISSUE, cs falls before the edge, so no write occurs.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - pN_ready = pN_valid & grant_N.
  - Grant: only one valid -> that port. Both valid -> the port != last_grant.
  - On handshake: latch port id, write, addr, wdata; update last_grant; go ISSUE.
  - ram_cs = 0 in IDLE.
- ISSUE (1 cycle):
  - In range: ram_cs = 1, ram_memRead = ~write, ram_memWrite = write, address and writeData driven. The RAM acts at the end edge.
  - Write -> IDLE.
  - Read -> CAPTURE.
  - Out of range: ram_cs = 0, no RAM access, oob_err pulses on entry to the next state. Write is dropped -> IDLE. Read -> CAPTURE with forced zero data.
- CAPTURE (1 cycle):
  - ram_cs held 1, memRead = memWrite = 0, so ram_readData stays stable and is not tri-stated.
  - At the end edge: pN_rdata <= ram_readData (0 if out of range), pN_rvalid <= 1, state -> IDLE.
- Timing:
  - Read: handshake edge E0 -> rvalid high in cycle after E0+2 (3-cycle latency).
  - Write: RAM updated at E0+1.
  - Throughput: 1 write/2 cycles, 1 read/3 cycles.
  - Accept in IDLE may coincide with the previous read's rvalid.
- No ready is asserted outside IDLE. A valid without a handshake never produces a RAM access.
- A port dropping valid before ready is a protocol error; it is not checked.
- last_grant updates only on handshake.

Decomposition:
- params.v (shared include) holds the bus widths and NUM_ADDRESSES. Add state encodings ST_IDLE / ST_ISSUE / ST_CAPTURE there as localparams.
- One sub-module: rr_arbiter2 (2-way round-robin).
  - Inputs: clk, reset, req[1:0], advance.
  - Outputs: grant[1:0] one-hot, plus the last_grant register.

Test Plan:
- Reset then p0 read addr 49 (RAM preloaded mem[i]=i) -> p0_ready at cycle 0, ram_cs/memRead high in cycle 1, p0_rvalid with p0_rdata=49 in cycle 3; p1 outputs stay 0.
- p1 write addr 7 data 0xDEAD, then p0 read addr 7 -> RAM row 7 = 0xDEAD after ISSUE; p0_rdata=0xDEAD.
- p0 and p1 both read (addr 1 / addr 2) held continuously -> grants alternate p0,p1,p0,p1; rdata 1,2,1,2; never two readies in one cycle.
- p0 read addr 600 (>=512) -> ram_cs never high, oob_err one pulse, p0_rvalid with p0_rdata=0. Then write addr 600 -> no RAM change, oob_err pulse, no rvalid.
- Reset asserted mid-ISSUE of write addr 3 data 0xFF -> all outputs 0 immediately, mem[3] stays 3, next request granted to p0.
- Back-to-back: p0 read addr 10 then p0 write addr 11 presented at rvalid cycle -> write accepted the same cycle rvalid is high; mem[11] updated 2 cycles later.
